// File: rtl/host_reg_pkg.sv
// Shared definitions for the host register slave: register indices,
// per-register field widths and reset values, and the stats FSM states.
package host_reg_pkg;

    localparam int NUM_REGS_DEF   = 35;
    localparam int RD_TIMEOUT_DEF = 255;

    // Register indices (ca[7:1])
    localparam int ADDR_TX_HWMARK    = 0;
    localparam int ADDR_TX_LWMARK    = 1;
    localparam int ADDR_R02          = 2;
    localparam int ADDR_R03          = 3;
    localparam int ADDR_IFG_SET      = 4;
    localparam int ADDR_FULL_DUPLEX  = 5;
    localparam int ADDR_MAX_RETRY    = 6;
    localparam int ADDR_R07          = 7;
    localparam int ADDR_TX_PROM_DATA = 8;
    localparam int ADDR_TX_PROM_ADD  = 9;
    localparam int ADDR_TX_PROM_WR   = 10;
    localparam int ADDR_R11          = 11;
    localparam int ADDR_R12          = 12;
    localparam int ADDR_R13          = 13;
    localparam int ADDR_R14          = 14;
    localparam int ADDR_RX_PROM_DATA = 15;
    localparam int ADDR_RX_PROM_ADD  = 16;
    localparam int ADDR_RX_PROM_WR   = 17;
    localparam int ADDR_R18          = 18;
    localparam int ADDR_R19          = 19;
    localparam int ADDR_R20          = 20;
    localparam int ADDR_R21          = 21;
    localparam int ADDR_RX_HWMARK    = 22;
    localparam int ADDR_RX_LWMARK    = 23;
    localparam int ADDR_CRC_CHK_EN   = 24;
    localparam int ADDR_RX_IFG_SET   = 25;
    localparam int ADDR_RX_MAX_LEN   = 26;
    localparam int ADDR_RX_MIN_LEN   = 27;
    localparam int ADDR_CPU_RD_ADDR  = 28;
    localparam int ADDR_CPU_RD_APPLY = 29;
    localparam int ADDR_GRANT_STATUS = 30;
    localparam int ADDR_DOUT_L       = 31;
    localparam int ADDR_DOUT_H       = 32;
    localparam int ADDR_R33          = 33;
    localparam int ADDR_SPEED        = 34;

    // Field width of each register; read-only entries describe what is shown.
    localparam int REG_WIDTH [0:34] = '{
        5, 5, 1, 16, 6,
        1, 4, 1, 8, 3,
        1, 1, 1, 1, 1,
        8, 3, 1, 1, 16,
        16, 1, 5, 5, 1,
        6, 16, 7, 6, 1,
        2, 16, 16, 1, 3
    };

    localparam logic [15:0] REG_RST [0:34] = '{
        16'h001E, 16'h0019, 16'h0000, 16'h0000, 16'h001E,
        16'h0001, 16'h0002, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h001A, 16'h0010, 16'h0001,
        16'h001E, 16'h2710, 16'h0040, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } stats_state_e;

    // Low-order ones mask for a field of the given width.
    function automatic logic [15:0] field_mask(input int width);
        if (width >= 16) begin
            return 16'hFFFF;
        end
        return 16'((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/stats_rd_ctrl.sv
// CPU statistics read handshake: issues apply, waits for grant or timeout,
// latches the 32-bit result and reports done/timeout status.
module stats_rd_ctrl
    import host_reg_pkg::*;
#(
    parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
    input  logic        clk_reg,
    input  logic        reset,
    input  logic        ctl_wr_i,
    input  logic        ctl_bit0_i,
    input  logic        grant_i,
    input  logic [31:0] dout_i,
    output logic        apply_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic [31:0] data_o
);

    localparam int CW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);

    stats_state_e  state_q;
    logic          apply_q;
    logic          done_q;
    logic          timeout_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   data_q;

    // Request/grant state machine with registered apply and status outputs.
    always_ff @(posedge clk_reg or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            apply_q   <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            data_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctl_wr_i && ctl_bit0_i) begin
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        cnt_q     <= '0;
                        apply_q   <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A grant beats a same-cycle abort so no data is lost.
                    if (grant_i) begin
                        data_q  <= dout_i;
                        done_q  <= 1'b1;
                        apply_q <= 1'b0;
                        state_q <= ST_DONE;
                    end else if (ctl_wr_i && !ctl_bit0_i) begin
                        apply_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CW'(RD_TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        apply_q   <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (ctl_wr_i) begin
                        if (ctl_bit0_i) begin
                            done_q    <= 1'b0;
                            timeout_q <= 1'b0;
                            cnt_q     <= '0;
                            apply_q   <= 1'b1;
                            state_q   <= ST_REQ;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    apply_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign apply_o   = apply_q;
    assign done_o    = done_q;
    assign timeout_o = timeout_q;
    assign data_o    = data_q;

endmodule

// File: rtl/host_reg_slave.sv
// Host-bus register slave: MAC configuration register file, read mux with
// hold register, address-PROM write strobes and stats readback.
module host_reg_slave
    import host_reg_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
    input  logic                     clk_reg,
    input  logic                     reset,
    input  logic                     csb,
    input  logic                     wrb,
    input  logic [7:0]               ca,
    input  logic [15:0]              cd_in,
    output logic [15:0]              cd_out,
    output logic [NUM_REGS*16-1:0]   cfg_flat,
    output logic                     tx_prom_wr,
    output logic                     rx_prom_wr,
    output logic [5:0]               cpu_rd_addr,
    output logic                     cpu_rd_apply,
    input  logic                     cpu_rd_grant,
    input  logic [31:0]              cpu_rd_dout
);

    logic [6:0]  idx;
    logic        host_wr;
    logic [15:0] reg_val [NUM_REGS];
    logic [15:0] rd_data;
    logic [15:0] hold_q;
    logic        tx_prom_wr_q;
    logic        rx_prom_wr_q;
    logic        stat_done;
    logic        stat_timeout;
    logic [31:0] stat_data;
    logic        unused_ca0;

    assign idx        = ca[7:1];
    assign host_wr    = !csb && !wrb;
    assign unused_ca0 = ca[0];

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        localparam logic [15:0] MASK = field_mask(REG_WIDTH[gi]);
        if (gi == ADDR_GRANT_STATUS) begin : g_status
            assign reg_val[gi] = {14'd0, stat_timeout, stat_done};
        end else if (gi == ADDR_DOUT_L) begin : g_dout_l
            assign reg_val[gi] = stat_data[15:0];
        end else if (gi == ADDR_DOUT_H) begin : g_dout_h
            assign reg_val[gi] = stat_data[31:16];
        end else begin : g_rw
            logic [15:0] val_q;
            // Host-writable register, stored already masked to its field width.
            always_ff @(posedge clk_reg or negedge reset) begin
                if (!reset) begin
                    val_q <= REG_RST[gi] & MASK;
                end else if (host_wr && idx == 7'(gi)) begin
                    val_q <= cd_in & MASK;
                end
            end
            assign reg_val[gi] = val_q;
        end
        assign cfg_flat[gi*16 +: 16] = reg_val[gi];
    end

    // Read mux: undecoded indices read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 7'(i)) begin
                rd_data = reg_val[i];
            end
        end
    end

    // Capture the addressed value on every selected cycle for idle-bus readback.
    always_ff @(posedge clk_reg or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
        end else if (!csb) begin
            hold_q <= rd_data;
        end
    end

    assign cd_out = csb ? hold_q : rd_data;

    // PROM strobes fire only on a 0->1 transition of the stored bit0.
    always_ff @(posedge clk_reg or negedge reset) begin
        if (!reset) begin
            tx_prom_wr_q <= 1'b0;
            rx_prom_wr_q <= 1'b0;
        end else begin
            tx_prom_wr_q <= host_wr && (idx == 7'(ADDR_TX_PROM_WR)) && cd_in[0]
                            && !reg_val[ADDR_TX_PROM_WR][0];
            rx_prom_wr_q <= host_wr && (idx == 7'(ADDR_RX_PROM_WR)) && cd_in[0]
                            && !reg_val[ADDR_RX_PROM_WR][0];
        end
    end

    assign tx_prom_wr  = tx_prom_wr_q;
    assign rx_prom_wr  = rx_prom_wr_q;
    assign cpu_rd_addr = reg_val[ADDR_CPU_RD_ADDR][5:0];

    stats_rd_ctrl #(
        .RD_TIMEOUT (RD_TIMEOUT)
    ) u_stats (
        .clk_reg    (clk_reg),
        .reset      (reset),
        .ctl_wr_i   (host_wr && (idx == 7'(ADDR_CPU_RD_APPLY))),
        .ctl_bit0_i (cd_in[0]),
        .grant_i    (cpu_rd_grant),
        .dout_i     (cpu_rd_dout),
        .apply_o    (cpu_rd_apply),
        .done_o     (stat_done),
        .timeout_o  (stat_timeout),
        .data_o     (stat_data)
    );

endmodule
